// File: rtl/dr_tx_hs_if.sv
// Bundle between the synchronous producer, the dual-rail transmitter and the async receiver.
// in/in_vld/in_rdy: valid/ready; a word moves on a clk edge where in_vld && in_rdy, and in must hold while in_vld is high and in_rdy is low.
interface dr_tx_hs_if #(
    parameter int N = 16
) ();
    logic [N-1:0]   in;
    logic           in_vld;
    logic           in_rdy;
    logic [2*N-1:0] out;
    logic           ack;

    modport master (
        output in, in_vld, ack,
        input  in_rdy, out
    );

    modport slave (
        input  in, in_vld, ack,
        output in_rdy, out
    );
endinterface

// File: rtl/dr_tx_hs.sv
// Sync-to-dual-rail transmitter: a word FIFO drained by a 4-phase RTZ sender.
// Every codeword is followed by an all-zero spacer before the next one is driven.
module dr_tx_hs #(
    parameter int N           = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    dr_tx_hs_if.slave                    bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         err,
    output logic [1:0]                   state_dbg
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RTZ = 2'd2} state_e;

    state_e                   state_q, state_d;
    logic [2*N-1:0]           out_q, out_d;
    logic                     err_q, err_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [N-1:0]             mem_q [DEPTH];
    logic                     push, pop, ack_s, non_empty;

    function automatic logic [2*N-1:0] encode(input logic [N-1:0] w);
        logic [2*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[2*i]   = ~w[i];
            r[2*i+1] = w[i];
        end
        return r;
    endfunction

    assign sync_d     = {sync_q[SYNC_STAGES-2:0], bus.ack};
    assign ack_s      = sync_q[SYNC_STAGES-1];
    assign non_empty  = (count_q != '0);
    assign bus.in_rdy = (count_q < CW'(DEPTH));
    assign push       = bus.in_vld && bus.in_rdy;

    // Pointers wrap on their own because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        err_d   = err_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ack_s) begin
                    err_d = 1'b1;
                end else if (non_empty) begin
                    out_d   = encode(mem_q[rd_ptr_q]);
                    pop     = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ack_s) begin
                    out_d   = '0;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (!ack_s) begin
                    if (non_empty) begin
                        out_d   = encode(mem_q[rd_ptr_q]);
                        pop     = 1'b1;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            err_q    <= err_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sync_q   <= sync_d;
        end
    end

    // Storage needs no reset: count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in;
    end

    assign bus.out   = out_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_dr_tx_hs.sv
// Directed bench for dr_tx_hs (N=16, DEPTH=4, SYNC_STAGES=2) with hand-computed codewords.
module tb_dr_tx_hs;
    localparam int N  = 16;
    localparam int SS = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic       busy;
    logic       err;
    logic [1:0] state_dbg;

    dr_tx_hs_if #(.N(N)) bus ();

    dr_tx_hs #(.N(N), .DEPTH(4), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .count     (count),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [2*N-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_nz(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out != '0) begin seen = 1'b1; break; end
            tick();
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_out_zero(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out == '0) begin seen = 1'b1; break; end
            tick();
        end
        check({tag, "_zero"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin seen = 1'b1; break; end
            tick();
        end
        check({tag, "_idle"}, 64'(seen), 64'd1);
    endtask

    task automatic push_word(input logic [N-1:0] d);
        logic acc = 1'b0;
        bus.in     = d;
        bus.in_vld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            acc = bus.in_rdy;
            tick();
            if (acc) break;
        end
        bus.in_vld = 1'b0;
        check("push_accept", 64'(acc), 64'd1);
    endtask

    // One full 4-phase transfer, receiver answering 2 cycles after each out change.
    task automatic hs(input string tag);
        logic [2*N-1:0] e;
        logic [2*N-1:0] cw;
        bit moved = 1'b0;
        wait_out_nz(tag);
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        cw = bus.out;
        check({tag, "_cw"}, 64'(bus.out), 64'(e));
        repeat (2) tick();
        bus.ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out != cw) begin moved = 1'b1; break; end
            tick();
        end
        check({tag, "_moved"}, 64'(moved), 64'd1);
        check({tag, "_spacer"}, 64'(bus.out), 64'd0);
        repeat (2) tick();
        bus.ack = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.in     = '0;
        bus.in_vld = 1'b0;
        bus.ack    = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_out",    64'(bus.out),    64'd0);
        check("rst_count",  64'(count),      64'd0);
        check("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_err",    64'(err),        64'd0);

        // Single word and its latency
        bus.in     = 16'h00A5;
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        check("t1_out_before", 64'(bus.out), 64'd0);
        check("t1_count1",     64'(count),   64'd1);
        tick();
        check("t1_cw",     64'(bus.out),   64'h55559966);
        check("t1_busy",   64'(busy),      64'd1);
        check("t1_count0", 64'(count),     64'd0);
        check("t1_state",  64'(state_dbg), 64'd1);
        bus.ack = 1'b1;
        cyc = 0;
        while (bus.out != '0 && cyc < SS + 1) begin
            tick();
            cyc++;
        end
        check("t1_spacer", 64'(bus.out), 64'd0);
        check("t1_rtz_busy", 64'(busy), 64'd1);
        bus.ack = 1'b0;
        wait_idle("t1");
        check("t1_busy_end", 64'(busy), 64'd0);

        // Fill while the receiver holds ack high
        exp_q.push_back(32'h55559966);
        push_word(16'h00A5);
        wait_out_nz("t2_w0");
        check("t2_w0_cw", 64'(bus.out), 64'(exp_q.pop_front()));
        bus.ack = 1'b1;
        wait_out_zero("t2_w0");
        exp_q.push_back(32'h55555555);
        exp_q.push_back(32'hAAAAAAAA);
        exp_q.push_back(32'h5555AAAA);
        exp_q.push_back(32'hAAAA5555);
        exp_q.push_back(32'h555555AA);
        bus.in_vld = 1'b1;
        bus.in = 16'h0000; tick(); check("t2_count1", 64'(count), 64'd1);
        bus.in = 16'hFFFF; tick(); check("t2_count2", 64'(count), 64'd2);
        bus.in = 16'h00FF; tick(); check("t2_count3", 64'(count), 64'd3);
        bus.in = 16'hFF00; tick(); check("t2_count4", 64'(count), 64'd4);
        check("t2_full_rdy", 64'(bus.in_rdy), 64'd0);
        bus.in = 16'h000F;
        repeat (3) tick();
        check("t2_full_hold", 64'(count), 64'd4);
        check("t2_full_rdy2", 64'(bus.in_rdy), 64'd0);
        bus.ack = 1'b0;
        push_word(16'h000F);
        check("t2_refill", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) hs("t2_drain");
        wait_idle("t2");
        check("t2_empty", 64'(count), 64'd0);

        // Stream of three words
        exp_q.push_back(32'h55555556);
        exp_q.push_back(32'hAAAAAAAA);
        exp_q.push_back(32'h95555555);
        push_word(16'h0001);
        push_word(16'hFFFF);
        push_word(16'h8000);
        for (int i = 0; i < 3; i++) hs("t3_stream");
        wait_idle("t3");
        check("t3_empty", 64'(count), 64'd0);
        check("t3_sb_left", 64'(exp_q.size()), 64'd0);

        // Protocol error
        repeat (4) tick();
        check("t4_err_pre", 64'(err), 64'd0);
        bus.ack = 1'b1;
        repeat (4) tick();
        check("t4_err", 64'(err), 64'd1);
        check("t4_out", 64'(bus.out), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        bus.ack = 1'b0;
        repeat (4) tick();
        check("t4_err_sticky", 64'(err), 64'd1);

        // Asynchronous reset in DATA with two words queued
        bus.in_vld = 1'b1;
        bus.in = 16'h00FF; tick();
        bus.in = 16'hFF00; tick();
        bus.in = 16'h0F0F; tick();
        bus.in_vld = 1'b0;
        check("t5_count2", 64'(count), 64'd2);
        check("t5_cw", 64'(bus.out), 64'h5555AAAA);
        rst_n = 1'b0;
        #2;
        check("t5_rst_out",   64'(bus.out),    64'd0);
        check("t5_rst_count", 64'(count),      64'd0);
        check("t5_rst_rdy",   64'(bus.in_rdy), 64'd1);
        check("t5_rst_busy",  64'(busy),       64'd0);
        check("t5_rst_err",   64'(err),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("t5_post_out",   64'(bus.out), 64'd0);
        check("t5_post_busy",  64'(busy),    64'd0);
        check("t5_post_count", 64'(count),   64'd0);

        // Push and pop on the same edge at count=2
        bus.in_vld = 1'b1;
        bus.in = 16'h00FF; tick();
        bus.in = 16'hFF00; tick();
        bus.in = 16'h0F0F; tick();
        bus.in_vld = 1'b0;
        check("t6_count2", 64'(count), 64'd2);
        bus.ack = 1'b1;
        wait_out_zero("t6_a");
        bus.ack = 1'b0;
        repeat (2) tick();
        check("t6_pre_count", 64'(count), 64'd2);
        check("t6_pre_out", 64'(bus.out), 64'd0);
        bus.in     = 16'h000F;
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        check("t6_same_cycle", 64'(count), 64'd2);
        check("t6_cw_b", 64'(bus.out), 64'hAAAA5555);
        exp_q.push_back(32'hAAAA5555);
        exp_q.push_back(32'h55AA55AA);
        exp_q.push_back(32'h555555AA);
        for (int i = 0; i < 3; i++) hs("t6_drain");
        wait_idle("t6");
        check("t6_empty", 64'(count), 64'd0);
        check("t6_err", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dr_tx_hs.md
DR_TX_HS -- requirements
Module: dr_tx_hs

Interface
REQ-001 SHALL have parameter N, default 16: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO depth in words; power of two, >= 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop count in the ack synchroniser, >= 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state rises on posedge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in, input, N: sync data word.
REQ-007 SHALL have port in_vld, input, 1: word on in is valid.
REQ-008 SHALL have port in_rdy, output, 1: FIFO can accept a word.
REQ-009 SHALL have port out, output, 2N: dual-rail async output, registered.
REQ-010 SHALL have port ack, input, 1: asynchronous 4-phase acknowledge from the receiver.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1): FIFO occupancy.
REQ-012 SHALL have port busy, output, 1: FSM is not IDLE.
REQ-013 SHALL have port err, output, 1: sticky protocol-violation flag.

Function
REQ-014 SHALL encode bit i as out[2i] = ~bit, out[2i+1] = bit; spacer = all zeros.
REQ-015 SHALL push in into FIFO on a clk edge where in_vld && in_rdy.
REQ-016 SHALL drive in_rdy = (count < DEPTH), derived only from registered count.
REQ-017 SHALL drop nothing and accept nothing when full; in_vld with in_rdy=0 is ignored.
REQ-018 SHALL keep count unchanged on a same-cycle push and pop, and never let count exceed DEPTH or wrap below 0.
REQ-019 SHALL wrap read/write pointers modulo DEPTH.
REQ-020 SHALL pass ack through SYNC_STAGES flops, giving ack_s; the FSM uses ack_s only.
REQ-021 SHALL implement FSM states IDLE, DATA, RTZ.
REQ-022 In IDLE, when FIFO is non-empty and ack_s=0, SHALL load out=encode(head), pop, and go to DATA.
REQ-023 In DATA, SHALL hold out until ack_s=1, then load out=spacer and go to RTZ.
REQ-024 In RTZ, SHALL hold spacer until ack_s=0; then, if non-empty, load next codeword, pop, and go to DATA; else go to IDLE.
REQ-025 SHALL never move out directly between two codewords; a spacer always intervenes.
REQ-026 SHALL change out only from register outputs, so it is glitch-free.
REQ-027 Latency: a word pushed into an empty FIFO at edge k, with FSM IDLE and ack_s=0, SHALL appear on out after edge k+1.
REQ-028 SHALL make a word pushed while the FSM is in DATA or RTZ wait in order; FIFO order SHALL be preserved.
REQ-029 SHALL set err when ack_s=1 is seen in IDLE; err holds until reset; FSM stays IDLE while ack_s=1.
REQ-030 SHALL drive busy = (state != IDLE).

Reset
REQ-031 On rst_n=0 SHALL immediately (asynchronously) force:
- out = 0
- state = IDLE
- count and pointers = 0
- synchroniser flops = 0
- err = 0
- so in_rdy = 1 and busy = 0.
REQ-032 On reset mid-transfer SHALL discard the FIFO contents and the in-flight word; operation resumes from IDLE after release.

Verification (N=16, DEPTH=4, SYNC_STAGES=2)
REQ-033 Single word: push 0x00A5 into an empty FIFO, ack=0 -> out=0x55559966 one cycle later, busy=1. Raise ack -> out=0 within SYNC_STAGES+1 cycles. Drop ack -> busy=0.
REQ-034 Fill: hold ack=1 after the first transfer and push 5 words -> count=4 and in_rdy=0 after the fourth buffered push; the fifth is not taken until a pop.
REQ-035 Stream: push 0x0001, 0xFFFF, 0x8000; receiver returns ack 2 cycles after each out change -> the codewords appear in that order, with a spacer between each, and no word is lost.
REQ-036 Protocol error: ack=1 while IDLE and empty -> err=1, out stays 0; err persists after ack=0.
REQ-037 Reset mid-DATA: drive rst_n=0 with out nonzero and count=2 -> out=0, count=0, in_rdy=1, busy=0, all with no clock edge.
REQ-038 Simultaneous: at count=2 with a pop in progress, push a word in the same cycle -> count stays 2.
